// File: rtl/i2c_clk_gen.sv
// i2c_clk_gen: I2C master SCL generator with clock stretching, halt and SCL-low time-out
module i2c_clk_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int TO_SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       core_en,
  input  logic       mode,
  input  logic       halt,
  input  logic       gen_en,
  input  logic [7:0] prescale,
  input  logic [7:0] time_out_reg,
  input  logic       scl_in,
  output logic       scl_oe,
  output logic       scl_sync,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       mid_low,
  output logic       mid_high,
  output logic       clk_busy,
  output logic       time_out,
  output logic       time_rst
);
  typedef enum logic [2:0] {IDLE, LOW1, LOW2, HWAIT, HIGH1, HIGH2} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic scl_prev;
  logic [7:0] cnt, cnt_nx;
  logic [11:0] low_cnt;
  logic [31:0] limit;
  logic run, freeze, hold0, tick, to_clr, hit, fired;
  assign scl_sync = sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_sync & ~scl_prev;
  assign scl_fall = ~scl_sync & scl_prev;
  assign run = core_en & mode;
  assign freeze = run & halt & (state == LOW1 || state == LOW2);
  assign hold0 = ~core_en | (state == HWAIT) | ((state == IDLE) & mode & ~(gen_en & ~halt));
  assign tick = core_en & ~freeze & (cnt >= prescale);
  assign cnt_nx = hold0 ? 8'd0 : freeze ? cnt : tick ? 8'd0 : cnt + 8'd1;
  assign scl_oe = (state == LOW1) || (state == LOW2);
  assign clk_busy = state != IDLE;
  assign to_clr = scl_sync | ~core_en;
  assign limit = 32'(time_out_reg) << TO_SHIFT;
  assign hit = (time_out_reg != 8'd0) & ~fired & ~to_clr & (32'(low_cnt) == limit);
  // SCL input synchroniser, idles high so reset alone never produces an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      scl_prev <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scl_in};
      scl_prev <= scl_sync;
    end
  end
  // state register and prescale tick counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 8'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // next state and SDA timing pulses; losing enable or master mode overrides everything
  always_comb begin
    state_nx = state;
    mid_low = 1'b0;
    mid_high = 1'b0;
    if (!run) state_nx = IDLE;
    else begin
      case (state)
        IDLE:  state_nx = (tick & gen_en & ~halt) ? LOW1 : IDLE;
        LOW1:  begin
          state_nx = tick ? LOW2 : LOW1;
          mid_low = tick;
        end
        LOW2:  state_nx = tick ? HWAIT : LOW2;
        HWAIT: state_nx = scl_sync ? HIGH1 : HWAIT;
        HIGH1: begin
          state_nx = tick ? HIGH2 : HIGH1;
          mid_high = tick;
        end
        HIGH2: state_nx = !tick ? HIGH2 : (gen_en & ~halt) ? LOW1 : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end
  // SCL-low counter and time-out flag; one pulse per low period, set beats clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_cnt <= 12'd0;
      fired <= 1'b0;
      time_rst <= 1'b0;
      time_out <= 1'b0;
    end else begin
      low_cnt <= to_clr ? 12'd0 : (tick && low_cnt != 12'hfff) ? low_cnt + 12'd1 : low_cnt;
      fired <= to_clr ? 1'b0 : fired | hit;
      time_rst <= hit;
      time_out <= hit ? 1'b1 : (scl_rise | ~core_en) ? 1'b0 : time_out;
    end
  end
endmodule

// File: tb/tb_i2c_clk_gen.sv
// tb_i2c_clk_gen: directed checks of SCL timing, stretching, halt, forced exits and time-out
module tb_i2c_clk_gen;
  logic clk = 0, rst = 0, core_en = 0, mode = 0, halt = 0, gen_en = 0, scl_hold = 0;
  logic [7:0] prescale = 0, time_out_reg = 0;
  logic scl_in, scl_oe, scl_sync, scl_rise, scl_fall, mid_low, mid_high, clk_busy, time_out, time_rst;
  int tests = 0, fails = 0;
  int ml_n = 0, mh_n = 0, rise_n = 0, fall_n = 0, trst_n = 0;
  typedef struct {logic [7:0] pre; int lo; int hi;} vec_t;
  vec_t vt[4];

  i2c_clk_gen dut (
    .clk(clk), .rst(rst), .core_en(core_en), .mode(mode), .halt(halt), .gen_en(gen_en),
    .prescale(prescale), .time_out_reg(time_out_reg), .scl_in(scl_in), .scl_oe(scl_oe),
    .scl_sync(scl_sync), .scl_rise(scl_rise), .scl_fall(scl_fall), .mid_low(mid_low),
    .mid_high(mid_high), .clk_busy(clk_busy), .time_out(time_out), .time_rst(time_rst)
  );

  assign scl_in = ~(scl_oe | scl_hold);
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mid_low) ml_n <= ml_n + 1;
    if (mid_high) mh_n <= mh_n + 1;
    if (scl_rise) rise_n <= rise_n + 1;
    if (scl_fall) fall_n <= fall_n + 1;
    if (time_rst) trst_n <= trst_n + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_oe(input logic v, input string name);
    int n = 0;
    while (scl_oe !== v && n < 300) begin
      cyc;
      n++;
    end
    if (scl_oe !== v) check({name, "_wait"}, int'(scl_oe), int'(v));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (clk_busy !== 1'b0 && n < 300) begin
      cyc;
      n++;
    end
    if (clk_busy !== 1'b0) check({name, "_idle_wait"}, int'(clk_busy), 0);
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (scl_oe === v && n < 300) begin
      n++;
      cyc;
    end
  endtask

  initial begin
    int a, b, n, lo, hi, o, k;
    vt[0] = '{8'd0, 2, 5};
    vt[1] = '{8'd1, 4, 7};
    vt[2] = '{8'd3, 8, 11};
    vt[3] = '{8'd7, 16, 19};
    cyc;
    cyc;
    check("rst_scl_oe", int'(scl_oe), 0);
    check("rst_clk_busy", int'(clk_busy), 0);
    check("rst_time_out", int'(time_out), 0);
    check("rst_time_rst", int'(time_rst), 0);
    check("rst_scl_sync", int'(scl_sync), 1);
    check("rst_mid_low", int'(mid_low), 0);
    rst = 1;
    repeat (5) cyc;
    check("no_fall_after_reset", fall_n, 0);
    core_en = 1;
    mode = 1;
    for (int i = 0; i < 4; i++) begin
      gen_en = 0;
      wait_idle("vec");
      prescale = vt[i].pre;
      gen_en = 1;
      wait_oe(1'b1, "vec_start");
      a = ml_n;
      b = mh_n;
      run_len(1'b1, lo);
      run_len(1'b0, hi);
      check($sformatf("low_len_p%0d", vt[i].pre), lo, vt[i].lo);
      check($sformatf("high_len_p%0d", vt[i].pre), hi, vt[i].hi);
      check($sformatf("mid_low_p%0d", vt[i].pre), ml_n - a, 1);
      check($sformatf("mid_high_p%0d", vt[i].pre), mh_n - b, 1);
    end
    gen_en = 0;
    wait_idle("stretch");
    prescale = 3;
    gen_en = 1;
    wait_oe(1'b1, "stretch_low");
    wait_oe(1'b0, "stretch_hwait");
    scl_hold = 1;
    a = mh_n;
    repeat (20) cyc;
    check("stretch_oe", int'(scl_oe), 0);
    check("stretch_busy", int'(clk_busy), 1);
    check("stretch_sync", int'(scl_sync), 0);
    check("stretch_no_mid_high", mh_n - a, 0);
    scl_hold = 0;
    run_len(1'b0, n);
    check("stretch_release_len", n, 11);
    check("stretch_mid_high", mh_n - a, 1);
    repeat (4) cyc;
    halt = 1;
    a = ml_n;
    b = mh_n;
    o = 0;
    repeat (50) begin
      cyc;
      if (scl_oe !== 1'b1) o++;
    end
    check("halt_oe_low", o, 0);
    check("halt_no_pulses", (ml_n - a) + (mh_n - b), 0);
    halt = 0;
    run_len(1'b1, n);
    check("halt_resume_len", n, 4);
    gen_en = 0;
    repeat (10) cyc;
    check("gen_off_busy_before", int'(clk_busy), 1);
    cyc;
    check("gen_off_busy_after", int'(clk_busy), 0);
    check("gen_off_oe", int'(scl_oe), 0);
    gen_en = 1;
    wait_oe(1'b1, "core_off");
    a = ml_n;
    repeat (3) cyc;
    core_en = 0;
    cyc;
    check("core_off_oe", int'(scl_oe), 0);
    check("core_off_busy", int'(clk_busy), 0);
    check("core_off_no_mid_low", ml_n - a, 0);
    core_en = 1;
    wait_oe(1'b1, "rst_mid");
    repeat (2) cyc;
    #1 rst = 0;
    #1;
    check("rst_mid_oe", int'(scl_oe), 0);
    check("rst_mid_busy", int'(clk_busy), 0);
    check("rst_mid_sync", int'(scl_sync), 1);
    a = fall_n;
    cyc;
    rst = 1;
    gen_en = 0;
    repeat (4) cyc;
    check("rst_mid_no_fall", fall_n - a, 0);
    mode = 0;
    prescale = 0;
    time_out_reg = 2;
    repeat (3) cyc;
    scl_hold = 1;
    n = 0;
    k = 0;
    while (time_rst !== 1'b1 && k < 200) begin
      cyc;
      k++;
      if (scl_sync === 1'b0 && time_rst !== 1'b1) n++;
    end
    check("to_seen", int'(time_rst), 1);
    check("to_low_clks", n, 33);
    check("to_flag_set", int'(time_out), 1);
    cyc;
    check("to_pulse_width", int'(time_rst), 0);
    a = trst_n;
    repeat (40) cyc;
    check("to_no_repulse", trst_n - a, 0);
    check("to_sticky", int'(time_out), 1);
    a = rise_n;
    scl_hold = 0;
    repeat (4) cyc;
    check("to_rise", rise_n - a, 1);
    check("to_cleared_on_rise", int'(time_out), 0);
    time_out_reg = 0;
    a = trst_n;
    scl_hold = 1;
    repeat (100) cyc;
    check("to_disabled_pulse", trst_n - a, 0);
    check("to_disabled_flag", int'(time_out), 0);
    scl_hold = 0;
    repeat (4) cyc;
    time_out_reg = 1;
    a = trst_n;
    scl_hold = 1;
    repeat (40) cyc;
    check("to_rearm_pulse", trst_n - a, 1);
    check("to_rearm_flag", int'(time_out), 1);
    core_en = 0;
    repeat (2) cyc;
    check("to_clr_core_off", int'(time_out), 0);
    scl_hold = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
